// File: rtl/_piso_tx_pkg.sv
// Shared constants for the _piso_tx serial transmitter slice: state
// encodings and default word/counter widths.
package _piso_tx_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_CNT_W = 5;

endpackage : _piso_tx_pkg

// File: rtl/_cnt_dn.sv
// Down-counter with synchronous load, count enable and zero flag.
// Counting stops at zero; a load always takes priority over the enable.
module _cnt_dn #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Load, decrement toward zero, or hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule : _cnt_dn

// File: rtl/_piso_tx.sv
// Parallel-in serial-out transmitter. Takes one WIDTH-bit word over a
// valid/ready handshake and plays it out MSB-first, one bit per shift_en
// strobe, then pulses done for one cycle.
// Optional feature: define PISO_TX_PARITY_EN to append an even-parity bit
// (^d) after the data bits, making a frame WIDTH+1 strobes long.
module _piso_tx
  import _piso_tx_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] d,
  output logic             in_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

`ifdef PISO_TX_PARITY_EN
  // Counter runs one step longer; cnt==0 selects the parity bit.
  localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(WIDTH);
`else
  localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(WIDTH - 1);
`endif

  logic             r_state;
  logic [WIDTH-1:0] r_shreg;
  logic             r_done;
  logic             w_load;
  logic             w_step;
  logic             w_zero;
  logic             w_bit;

  assign w_load = (r_state == ST_IDLE) && in_valid && !rst;
  assign w_step = (r_state == ST_SHIFT) && shift_en;

  _cnt_dn #(
    .W (CNT_W)
  ) u_bit_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (LOAD_CNT),
    .i_en       (w_step),
    .o_zero     (w_zero)
  );

  // State, shift register and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_shreg <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_state <= ST_SHIFT;
            r_shreg <= d;
          end
        end
        default: begin
          if (w_step) begin
            if (w_zero) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
            end
          end
        end
      endcase
    end
  end

`ifdef PISO_TX_PARITY_EN
  logic r_par;

  // Even parity of the accepted word, captured at load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_par <= 1'b0;
    end else if (w_load) begin
      r_par <= ^d;
    end
  end

  assign w_bit = w_zero ? r_par : r_shreg[WIDTH-1];
`else
  assign w_bit = r_shreg[WIDTH-1];
`endif

  assign in_ready   = (r_state == ST_IDLE) && !rst;
  assign sout_valid = (r_state == ST_SHIFT);
  assign sout       = sout_valid & w_bit;
  assign done       = r_done;

endmodule : _piso_tx

// File: doc/_piso_tx.md
Name: _piso_tx

Overview:
- Parallel-in, serial-out transmitter. Accepts one WIDTH-bit word over a valid/ready handshake and shifts it out MSB-first, one bit per shift_en strobe.
- Counterpart to the team's serial-capture side: the storage elements load a word, and this block plays it back bit by bit.
- Sits between a word producer and a serial line whose bit timing comes from an external strobe (baud tick or divided clock).

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..32.
- CNT_W, 5, bit-counter width; must satisfy 2**CNT_W >= WIDTH+1.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word on d.
- d  input  WIDTH  parallel word to transmit.
- in_ready  output  1  block can accept a word.
- shift_en  input  1  bit strobe; advances the serial output by one bit.
- sout  output  1  serial data, MSB first.
- sout_valid  output  1  sout carries a frame bit.
- done  output  1  one-cycle pulse after the last bit is consumed.

Behaviour:
- Reset: one clock, one reset; reset is synchronous and active-high.
  - rst sampled high at posedge clk sets state=IDLE, shreg=0, cnt=0, done=0.
  - Resulting outputs: sout=0, sout_valid=0, in_ready=1 from the first cycle after rst deasserts.
  - While rst is high, in_ready is forced to 0.
- States:
  - IDLE: in_ready=1, sout_valid=0, sout=0.
  - SHIFT: in_ready=0, sout_valid=1, sout=shreg[MSB].
- IDLE->SHIFT: on posedge with in_valid && in_ready.
  - shreg<=d, cnt<=WIDTH-1.
  - The first bit d[WIDTH-1] appears on sout in the next cycle.
- SHIFT with shift_en=1 and cnt!=0: shreg<=shreg<<1 (LSB filled with 0), cnt<=cnt-1.
- SHIFT with shift_en=1 and cnt==0: state<=IDLE and done<=1 for exactly one cycle. in_ready returns to 1 in the same cycle as done.
- SHIFT with shift_en=0: shreg, cnt and sout all hold. Each bit stays on sout until the strobe that consumes it.
- Frame length: exactly WIDTH shift_en strobes. Strobes seen in IDLE are ignored.
- in_valid while in SHIFT: ignored. in_ready=0, so no word is taken and nothing is queued.
- Back-to-back frames: in_valid held high makes the load happen in the done cycle. Minimum gap between frames is one cycle with sout_valid=0.
- shift_en in the load cycle: ignored. The first strobe that counts is in the first SHIFT cycle.
- rst mid-frame: the frame is aborted and no done pulse is issued. Next cycle is IDLE with all outputs at reset values.
- All outputs are registered or decoded from state only. There is no combinational path from in_valid or d to the outputs.

Optional Feature:
- Macro: PISO_TX_PARITY_EN.
- Defined:
  - At load, even parity ^d is captured into a parity register.
  - After the data bits, SHIFT presents the parity bit on sout for one extra strobe, so a frame is WIDTH+1 strobes.
  - done follows the parity bit.
  - cnt loads WIDTH instead of WIDTH-1; the parity bit is presented when cnt==0.
- Undefined: no parity logic and a WIDTH-strobe frame, as described above.

Decomposition:
- Shared package or include file holds:
  - state encodings: ST_IDLE=1'b0, ST_SHIFT=1'b1;
  - the default WIDTH and CNT_W constants.
- One natural sub-module, _cnt_dn: down-counter with synchronous load, enable and a zero flag. _piso_tx instantiates it as the bit counter.
- The shift register stays inline.

Test Plan:
- Reset: hold rst 3 cycles with in_valid=1 and d=8'hFF -> in_ready=0 during rst. Cycle after release: in_ready=1, sout_valid=0, sout=0, done=0.
- Basic frame: load 8'hA5, shift_en tied to 1 -> sout=1,0,1,0,0,1,0,1 over 8 consecutive cycles with sout_valid=1. done pulses in cycle 9, where in_ready=1.
- Gated strobe: load 8'h3C, shift_en high every 3rd cycle -> each bit held exactly 3 cycles. Sequence is 0,0,1,1,1,1,0,0 and done follows the 8th strobe.
- Busy/back-to-back: keep in_valid=1 with d=8'h81 mid-frame -> not accepted mid-frame. It loads in the done cycle and the second frame starts after a one-cycle gap.
- Mid-frame reset: assert rst after 3 bits of 8'hF0 -> no done. Next cycle is IDLE, and a subsequent 8'h0F frame transmits correctly.
- PISO_TX_PARITY_EN: 8'h07 -> 9 bits 0,0,0,0,0,1,1,1,1 (parity 1). 8'h03 -> parity bit 0, and done follows the 9th strobe.
